// File: rtl/aes_gcm_decrypt_verify_if.sv
`default_nettype none
// ============================================================================
//  Module      : aes_gcm_decrypt_verify_if
//  Description : Request/acknowledge port to the shared AES-256 block core.
//                The engine is the master: it raises aes_req with a stable
//                aes_in and the core answers with aes_ack / aes_out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface aes_gcm_decrypt_verify_if;
    logic         aes_req;
    logic [127:0] aes_in;
    logic         aes_ack;
    logic [127:0] aes_out;

    modport master (output aes_req, output aes_in, input aes_ack, input aes_out);
    modport slave  (input aes_req, input aes_in, output aes_ack, output aes_out);
endinterface
`default_nettype wire

// File: rtl/aes_gcm_decrypt_verify.sv
`default_nettype none
// ============================================================================
//  Module      : aes_gcm_decrypt_verify
//  Description : GCM-AES-256 receive path. Fetches H, E(J0) and three key-
//                stream blocks from the shared AES core, runs GHASH over the
//                AAD, ciphertext and length block on a digit-serial GF(2^128)
//                multiplier, and releases plaintext only on a tag match.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_gcm_decrypt_verify #(
    parameter int DIGIT         = 1,
    parameter bit CLEAR_ON_FAIL = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [95:0]                     nonce,
    input  logic [223:0]                    aad,
    input  logic [127:0]                    ct1,
    input  logic [127:0]                    ct2,
    input  logic [127:0]                    ct3,
    input  logic [127:0]                    tag_in,
    aes_gcm_decrypt_verify_if.master        aes,
    output logic [127:0]                    pt1,
    output logic [127:0]                    pt2,
    output logic [127:0]                    pt3,
    output logic [127:0]                    tag_calc,
    output logic                            auth_ok,
    output logic                            busy,
    output logic                            done
);

    localparam int           STEPS     = 128 / DIGIT;
    localparam logic [6:0]   LAST_STEP = 7'(STEPS - 1);
    localparam logic [127:0] GF_R      = {8'hE1, 120'h0};

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_AES_H   = 4'd1,
        S_AES_J0  = 4'd2,
        S_AES_K2  = 4'd3,
        S_AES_K3  = 4'd4,
        S_AES_K4  = 4'd5,
        S_GH_LOAD = 4'd6,
        S_GH_MUL  = 4'd7,
        S_FINAL   = 4'd8,
        S_DONE    = 4'd9
    } state_t;

    state_t         state_q, state_d;
    logic           req_q, req_d;
    logic [127:0]   ain_q, ain_d;
    logic [95:0]    nonce_q, nonce_d;
    logic [223:0]   aad_q, aad_d;
    logic [127:0]   ct1_q, ct1_d, ct2_q, ct2_d, ct3_q, ct3_d, tagr_q, tagr_d;
    logic [127:0]   h_q, h_d, ej0_q, ej0_d;
    logic [127:0]   praw1_q, praw1_d, praw2_q, praw2_d, praw3_q, praw3_d;
    logic [127:0]   y_q, y_d, x_q, x_d, z_q, z_d, v_q, v_d;
    logic [6:0]     cnt_q, cnt_d;
    logic [2:0]     blk_q, blk_d;
    logic [127:0]   pt1_q, pt1_d, pt2_q, pt2_d, pt3_q, pt3_d, tagc_q, tagc_d;
    logic           ok_q, ok_d, done_q, done_d;

    logic [127:0]   w_aes_blk, w_gh_blk, w_z_step, w_v_step, w_tag;
    logic           w_match;

    assign w_tag   = y_q ^ ej0_q;
    assign w_match = (w_tag == tagr_q);

    // AES input for the current request: zero block for H, else counter blocks
    always_comb begin
        w_aes_blk = 128'h0;
        case (state_q)
            S_AES_J0: w_aes_blk = {nonce_q, 32'd1};
            S_AES_K2: w_aes_blk = {nonce_q, 32'd2};
            S_AES_K3: w_aes_blk = {nonce_q, 32'd3};
            S_AES_K4: w_aes_blk = {nonce_q, 32'd4};
            default:  w_aes_blk = 128'h0;
        endcase
    end

    // GHASH block sequence: two AAD blocks, three ciphertext blocks, lengths
    always_comb begin
        case (blk_q)
            3'd0:    w_gh_blk = aad_q[223:96];
            3'd1:    w_gh_blk = {aad_q[95:0], 32'h0};
            3'd2:    w_gh_blk = ct1_q;
            3'd3:    w_gh_blk = ct2_q;
            3'd4:    w_gh_blk = ct3_q;
            default: w_gh_blk = {64'd224, 64'd384};
        endcase
    end

    // One multiplier step: DIGIT bits of X consumed MSB-first per cycle
    always_comb begin
        w_z_step = z_q;
        w_v_step = v_q;
        for (int i = 0; i < DIGIT; i++) begin
            if (x_q[127 - i]) begin
                w_z_step = w_z_step ^ w_v_step;
            end
            w_v_step = (w_v_step >> 1) ^ (w_v_step[0] ? GF_R : 128'h0);
        end
    end

    // Sequencer next-state: AES handshakes, GHASH load/multiply, tag check
    always_comb begin
        state_d = state_q;  req_d   = req_q;   ain_d   = ain_q;
        nonce_d = nonce_q;  aad_d   = aad_q;   ct1_d   = ct1_q;
        ct2_d   = ct2_q;    ct3_d   = ct3_q;   tagr_d  = tagr_q;
        h_d     = h_q;      ej0_d   = ej0_q;   praw1_d = praw1_q;
        praw2_d = praw2_q;  praw3_d = praw3_q; y_d     = y_q;
        x_d     = x_q;      z_d     = z_q;     v_d     = v_q;
        cnt_d   = cnt_q;    blk_d   = blk_q;   pt1_d   = pt1_q;
        pt2_d   = pt2_q;    pt3_d   = pt3_q;   tagc_d  = tagc_q;
        ok_d    = ok_q;     done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    nonce_d = nonce;  aad_d = aad;  ct1_d = ct1;  ct2_d = ct2;
                    ct3_d   = ct3;    tagr_d = tag_in;
                    pt1_d   = '0;     pt2_d = '0;   pt3_d = '0;
                    tagc_d  = '0;     ok_d  = 1'b0;
                    y_d     = '0;     blk_d = '0;
                    state_d = S_AES_H;
                end
            end
            S_AES_H, S_AES_J0, S_AES_K2, S_AES_K3, S_AES_K4: begin
                // Request rises one cycle after the previous ack, never in it
                if (!req_q) begin
                    req_d = 1'b1;
                    ain_d = w_aes_blk;
                end else if (aes.aes_ack) begin
                    req_d = 1'b0;
                    case (state_q)
                        S_AES_H:  begin h_d     = aes.aes_out;         state_d = S_AES_J0;  end
                        S_AES_J0: begin ej0_d   = aes.aes_out;         state_d = S_AES_K2;  end
                        S_AES_K2: begin praw1_d = ct1_q ^ aes.aes_out; state_d = S_AES_K3;  end
                        S_AES_K3: begin praw2_d = ct2_q ^ aes.aes_out; state_d = S_AES_K4;  end
                        default:  begin praw3_d = ct3_q ^ aes.aes_out; state_d = S_GH_LOAD; end
                    endcase
                end
            end
            S_GH_LOAD: begin
                x_d     = y_q ^ w_gh_blk;
                z_d     = '0;
                v_d     = h_q;
                cnt_d   = '0;
                state_d = S_GH_MUL;
            end
            S_GH_MUL: begin
                x_d   = x_q << DIGIT;
                z_d   = w_z_step;
                v_d   = w_v_step;
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == LAST_STEP) begin
                    y_d = w_z_step;
                    if (blk_q == 3'd5) begin
                        state_d = S_FINAL;
                    end else begin
                        blk_d   = blk_q + 3'd1;
                        state_d = S_GH_LOAD;
                    end
                end
            end
            S_FINAL: begin
                tagc_d  = w_tag;
                ok_d    = w_match;
                pt1_d   = (w_match || !CLEAR_ON_FAIL) ? praw1_q : 128'h0;
                pt2_d   = (w_match || !CLEAR_ON_FAIL) ? praw2_q : 128'h0;
                pt3_d   = (w_match || !CLEAR_ON_FAIL) ? praw3_q : 128'h0;
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything and aborts work
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;  req_q   <= 1'b0;  ain_q   <= '0;  nonce_q <= '0;
            aad_q   <= '0;      ct1_q   <= '0;    ct2_q   <= '0;  ct3_q   <= '0;
            tagr_q  <= '0;      h_q     <= '0;    ej0_q   <= '0;  praw1_q <= '0;
            praw2_q <= '0;      praw3_q <= '0;    y_q     <= '0;  x_q     <= '0;
            z_q     <= '0;      v_q     <= '0;    cnt_q   <= '0;  blk_q   <= '0;
            pt1_q   <= '0;      pt2_q   <= '0;    pt3_q   <= '0;  tagc_q  <= '0;
            ok_q    <= 1'b0;    done_q  <= 1'b0;
        end else begin
            state_q <= state_d; req_q   <= req_d; ain_q   <= ain_d; nonce_q <= nonce_d;
            aad_q   <= aad_d;   ct1_q   <= ct1_d; ct2_q   <= ct2_d; ct3_q   <= ct3_d;
            tagr_q  <= tagr_d;  h_q     <= h_d;   ej0_q   <= ej0_d; praw1_q <= praw1_d;
            praw2_q <= praw2_d; praw3_q <= praw3_d; y_q   <= y_d;   x_q     <= x_d;
            z_q     <= z_d;     v_q     <= v_d;   cnt_q   <= cnt_d; blk_q   <= blk_d;
            pt1_q   <= pt1_d;   pt2_q   <= pt2_d; pt3_q   <= pt3_d; tagc_q  <= tagc_d;
            ok_q    <= ok_d;    done_q  <= done_d;
        end
    end

    assign aes.aes_req = req_q;
    assign aes.aes_in  = ain_q;
    assign pt1         = pt1_q;
    assign pt2         = pt2_q;
    assign pt3         = pt3_q;
    assign tag_calc    = tagc_q;
    assign auth_ok     = ok_q;
    assign done        = done_q;
    assign busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: doc/aes_gcm_decrypt_verify.md
Name: aes_gcm_decrypt_verify

Overview:
- GCM-AES-256 decryption and tag-verification engine; the receive-side counterpart of the existing encrypt top.
- Fixed packet format matches the encrypt top: 96-bit nonce, 224-bit AAD, three 128-bit ciphertext blocks, 128-bit received tag.
- Block-cipher work goes out through a req/ack port to the shared AES-256 core, which holds the key; GHASH runs on an internal digit-serial GF(2^128) multiplier.
- Plaintext is released only if the tag verifies.

Parameters:
- DIGIT, 1, multiplier bits per cycle (legal values 1, 2, 4, 8); one multiply takes 128/DIGIT cycles.
- CLEAR_ON_FAIL, 1, if 1 then plaintext outputs are forced to zero on a tag mismatch; if 0 they hold the raw decrypted value.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high; clock clk
- start  in  1  single-cycle start pulse; sampled only in IDLE
- nonce  in  96  IV; sampled at start
- aad  in  224  AAD, MSB = first byte; sampled at start
- ct1, ct2, ct3  in  128  ciphertext blocks; sampled at start
- tag_in  in  128  received tag; sampled at start
- aes_req  out  1  AES request
- aes_in  out  128  AES input block
- aes_ack  in  1  AES result valid
- aes_out  in  128  AES result
- pt1, pt2, pt3  out  128  recovered plaintext
- tag_calc  out  128  computed tag
- auth_ok  out  1  tag matched
- busy  out  1  high whenever not in IDLE
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs and internal registers go to 0; FSM goes to IDLE. Reset mid-operation aborts immediately and drops aes_req in the next cycle. Reset has priority over start.
- start:
  - In IDLE, start latches all inputs and clears pt*, tag_calc and auth_ok.
  - While busy, start is ignored.
- AES handshake:
  - aes_req rises together with a stable aes_in.
  - Both hold until aes_ack is sampled high; aes_out is captured in that same cycle.
  - aes_req drops in the next cycle. There is no back-to-back request in the ack cycle.
  - aes_ack seen while aes_req is low is ignored.
- FSM: IDLE -> AES_H -> AES_J0 -> AES_K2 -> AES_K3 -> AES_K4 -> GH_LOAD/GH_MUL (x6) -> FINAL -> DONE -> IDLE.
- AES inputs:
  - AES_H: aes_in = 128'h0; result is H.
  - AES_J0: aes_in = {nonce, 32'd1}; result is EJ0.
  - AES_Kn: aes_in = {nonce, 32'dn} for n = 2, 3, 4.
  - pt_i = ct_i XOR K(i+1), stored internally.
- GHASH:
  - Y starts at 0.
  - Block sequence: B1 = aad[223:96]; B2 = {aad[95:0], 32'h0}; B3..B5 = ct1..ct3 (the ciphertext, not the plaintext); B6 = {64'd224, 64'd384}.
  - GH_LOAD is 1 cycle: X = Y XOR Bi, Z = 0, V = H.
  - GH_MUL runs 128/DIGIT cycles. Each bit j, processed MSB-first (X[127] first):
    - if X bit set, Z ^= V;
    - then V = (V >> 1) XOR (V[0] ? 128'hE1<<120 : 0).
  - At the end of GH_MUL, Y = Z.
  - Total GHASH time: 6*(128/DIGIT + 1) cycles.
- FINAL (1 cycle):
  - tag_calc = Y XOR EJ0.
  - auth_ok = (tag_calc == tag_in), a full 128-bit compare with no partial match.
  - pt1..pt3 are driven with the decrypted values if auth_ok, else 0 when CLEAR_ON_FAIL = 1.
- DONE: done = 1 for exactly one cycle, then the FSM returns to IDLE.
- Output hold: pt*, tag_calc and auth_ok hold until the next accepted start or reset.
- Latency: with AES ack latency L cycles after req (L >= 1), start-to-done = 1 + 5*(L+1) + 6*(128/DIGIT+1) + 2 cycles.

Test Plan:
- Bench setup: AES port driven by a behavioural AES-256 model with key E3C08A8F06C6E3AD95A70557B23F75483CE33021A9C72B7025666204C69C0B72 and L = 1.
- Good packet: nonce 12153524C0895E81B2C28465; aad D609B1F056637A0D46DF998D88E52E00B2C2846512153524C0895E81; ct e2006eb42f5277022d9b19925bc419d7 / a592666c925fe2ef718eb4e308efeaa7 / c5273b394118860a5be2a97f56ab7836; tag_in 5ca597cdbb3edb8d1a1151ea0af7b436 -> pt 08000F101112131415161718191A1B1C / 1D1E1F202122232425262728292A2B2C / 2D2E2F303132333435363738393A0002, auth_ok = 1, tag_calc = tag_in, one done pulse, start-to-done cycles match the formula.
- Same packet with tag_in bit 0 flipped -> auth_ok = 0, tag_calc = 5ca597cd...b436, pt1..3 = 0 (CLEAR_ON_FAIL = 1).
- Same packet with ct2 bit 127 flipped -> auth_ok = 0, pt = 0.
- Randomised aes_ack latency of 1-7 cycles, plus DIGIT = 4 build -> identical outputs; aes_in stable for every req-high cycle; no req in the cycle after ack.
- start re-pulsed while busy -> ignored, single done pulse. Reset asserted during GH_MUL -> all outputs 0 and aes_req 0 next cycle; a fresh start afterwards completes correctly.
